// File: rtl/lsu_ctrl_if.sv
// Interfaces for the load/store sequencer.
//
// lsu_req_if : execute-stage side. One decoded load/store per transaction
//              (valid/ready), plus the writeback, stall and exception
//              results the controller returns to the pipeline.
//   master = pipeline, slave = lsu_ctrl
//     valid, is_store, funct3, rs1, imm, store_data, rd   pipeline -> lsu
//     ready, wb_valid, wb_rd, wb_data, stall,
//     exc_valid, exc_cause, exc_addr                      lsu -> pipeline
//
// lsu_mem_if : data-memory port. Request valid/ready, read data returned
//              later with rvalid.
//   master = lsu_ctrl, slave = memory
//     valid, we, addr, wdata, be                          lsu -> memory
//     ready, rvalid, rdata                                memory -> lsu

interface lsu_req_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic            is_store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [11:0]     imm;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            exc_valid;
  logic [1:0]      exc_cause;
  logic [XLEN-1:0] exc_addr;

  modport master (
    output valid, is_store, funct3, rs1, imm, store_data, rd,
    input  ready, wb_valid, wb_rd, wb_data, stall, exc_valid, exc_cause, exc_addr
  );

  modport slave (
    input  valid, is_store, funct3, rs1, imm, store_data, rd,
    output ready, wb_valid, wb_rd, wb_data, stall, exc_valid, exc_cause, exc_addr
  );
endinterface

interface lsu_mem_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output valid, we, addr, wdata, be,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, be,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and the
// data-memory port. Forms ea = rs1 + sext(imm), checks legality and
// alignment, issues one memory request, aligns/extends load data and
// returns it as a one-cycle writeback pulse. Faults and memory timeouts
// are reported as a one-cycle exception pulse. All outputs are registered.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   req    lsu_req_if.slave  request in, writeback/stall/exception out
//   mem    lsu_mem_if.master memory request out, read data in

module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic            timeout;

  logic [XLEN-1:0] ea_r;
  logic [2:0]      f3_r;
  logic [4:0]      rd_r;
  logic            store_r;

  logic [XLEN-1:0] ea_in;
  logic            illegal, misaligned, fault;
  logic [3:0]      be_in;
  logic [XLEN-1:0] wdata_in;
  logic [XLEN-1:0] lane, load_val;

  logic            ready_q, stall_q, mvalid_q, we_q, wbv_q, excv_q;
  logic [XLEN-1:0] addr_q, wdata_q, wbdata_q, excaddr_q;
  logic [3:0]      be_q;
  logic [4:0]      wbrd_q;
  logic [1:0]      cause_q;

  logic            ready_n, stall_n, mvalid_n, we_n, wbv_n, excv_n;
  logic [XLEN-1:0] addr_n, wdata_n, wbdata_n, excaddr_n;
  logic [3:0]      be_n;
  logic [4:0]      wbrd_n;
  logic [1:0]      cause_n;

  // Decode of the incoming request: effective address, legality, alignment,
  // byte enables and lane-replicated store data.
  always_comb begin
    ea_in = req.rs1 + {{(XLEN-12){req.imm[11]}}, req.imm};
    if (req.is_store)
      illegal = req.funct3[2] | (req.funct3[1:0] == 2'b11);
    else
      illegal = (req.funct3[1:0] == 2'b11) | (req.funct3 == 3'b110);
    case (req.funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        be_in      = 4'b0001 << ea_in[1:0];
        wdata_in   = {(XLEN/8){req.store_data[7:0]}};
      end
      2'b01: begin
        misaligned = ea_in[0];
        be_in      = 4'b0011 << ea_in[1:0];
        wdata_in   = {(XLEN/16){req.store_data[15:0]}};
      end
      default: begin
        misaligned = |ea_in[1:0];
        be_in      = 4'b1111;
        wdata_in   = req.store_data;
      end
    endcase
    fault = illegal | misaligned;
  end

  // Load-data alignment: shift the addressed lane down, then extend by size.
  always_comb begin
    lane = mem.rdata >> {ea_r[1:0], 3'b000};
    case (f3_r)
      3'b000:  load_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // Next-state logic. The wait counter restarts on entry to REQ/WAIT_RD;
  // a handshake or rvalid in the cycle the limit is reached takes priority.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cnt_inc = cnt + CW'(1);
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (req.valid && !fault) begin
          state_n = REQ;
          cnt_n   = '0;
        end
      end
      REQ: begin
        if (mem.ready) begin
          state_n = store_r ? IDLE : WAIT_RD;
          cnt_n   = '0;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_n = IDLE;
          timeout = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      WAIT_RD: begin
        if (mem.rvalid) begin
          state_n = RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_n = IDLE;
          timeout = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs. Status flags follow the next
  // state; bus/data fields are loaded on the relevant transition and held.
  always_comb begin
    ready_n   = (state_n == IDLE);
    stall_n   = (state_n != IDLE);
    mvalid_n  = (state_n == REQ);
    we_n      = we_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    be_n      = be_q;
    wbv_n     = 1'b0;
    wbrd_n    = wbrd_q;
    wbdata_n  = wbdata_q;
    excv_n    = 1'b0;
    cause_n   = cause_q;
    excaddr_n = excaddr_q;
    if (state == IDLE && req.valid) begin
      if (fault) begin
        excv_n    = 1'b1;
        cause_n   = illegal ? 2'd3 : {1'b0, req.is_store};
        excaddr_n = ea_in;
      end else begin
        we_n    = req.is_store;
        addr_n  = {ea_in[XLEN-1:2], 2'b00};
        wdata_n = wdata_in;
        be_n    = be_in;
      end
    end
    // Writeback to x0 is suppressed but RESP is still visited.
    if (state == WAIT_RD && mem.rvalid) begin
      wbv_n    = (rd_r != 5'd0);
      wbrd_n   = rd_r;
      wbdata_n = load_val;
    end
    if (timeout) begin
      excv_n    = 1'b1;
      cause_n   = 2'd2;
      excaddr_n = ea_r;
    end
  end

  // State, transaction context and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ea_r      <= '0;
      f3_r      <= '0;
      rd_r      <= '0;
      store_r   <= 1'b0;
      ready_q   <= 1'b1;
      stall_q   <= 1'b0;
      mvalid_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wbv_q     <= 1'b0;
      wbrd_q    <= '0;
      wbdata_q  <= '0;
      excv_q    <= 1'b0;
      cause_q   <= '0;
      excaddr_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      if (state == IDLE && req.valid) begin
        ea_r    <= ea_in;
        f3_r    <= req.funct3;
        rd_r    <= req.rd;
        store_r <= req.is_store;
      end
      ready_q   <= ready_n;
      stall_q   <= stall_n;
      mvalid_q  <= mvalid_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      be_q      <= be_n;
      wbv_q     <= wbv_n;
      wbrd_q    <= wbrd_n;
      wbdata_q  <= wbdata_n;
      excv_q    <= excv_n;
      cause_q   <= cause_n;
      excaddr_q <= excaddr_n;
    end
  end

  assign req.ready     = ready_q;
  assign req.stall     = stall_q;
  assign req.wb_valid  = wbv_q;
  assign req.wb_rd     = wbrd_q;
  assign req.wb_data   = wbdata_q;
  assign req.exc_valid = excv_q;
  assign req.exc_cause = cause_q;
  assign req.exc_addr  = excaddr_q;
  assign mem.valid     = mvalid_q;
  assign mem.we        = we_q;
  assign mem.addr      = addr_q;
  assign mem.wdata     = wdata_q;
  assign mem.be        = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. Directed cases from the
// test plan followed by randomized transactions, each compared against a
// behavioural model of the access (byte-level arithmetic on the address,
// size and data). Inputs are driven and outputs sampled on the falling edge.

module tb_lsu_ctrl;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lsu_req_if #(.XLEN(XLEN)) req ();
  lsu_mem_if #(.XLEN(XLEN)) mem ();

  lsu_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .mem   (mem)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          fault;
    logic [1:0]  cause;
    logic [31:0] ea;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wb;
    logic [3:0]  be;
  } exp_t;

  // Counts one comparison and reports it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model of one access, from address arithmetic and byte lanes.
  function automatic exp_t model(input bit st, input logic [2:0] f3, input logic [31:0] rs1,
                                 input logic [11:0] imm, input logic [31:0] sd,
                                 input logic [31:0] rdata);
    exp_t        e;
    int          sx, size, off;
    bit          legal;
    logic [31:0] mask;
    sx      = $signed(imm);
    e.ea    = rs1 + 32'(sx);
    size    = 1 << f3[1:0];
    off     = int'(e.ea % 4);
    legal   = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e.fault = !legal || (e.ea % size != 0);
    e.cause = !legal ? 2'd3 : (st ? 2'd1 : 2'd0);
    e.addr  = e.ea - 32'(off);
    e.be    = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
    e.wb = (rdata >> (8*off)) & mask;
    if (!f3[2] && size < 4 && e.wb[8*size-1]) e.wb = e.wb | ~mask;
    return e;
  endfunction

  task automatic checkTimeout(input logic [31:0] ea);
    checkOutput("timeout_exc_valid", 32'(req.exc_valid), 32'd1);
    checkOutput("timeout_cause", 32'(req.exc_cause), 32'd2);
    checkOutput("timeout_addr", req.exc_addr, ea);
    checkOutput("timeout_mem_valid", 32'(mem.valid), 32'd0);
    checkOutput("timeout_ready", 32'(req.ready), 32'd1);
    checkOutput("timeout_no_wb", 32'(req.wb_valid), 32'd0);
    @(negedge clk);
    checkOutput("timeout_pulse_end", 32'(req.exc_valid), 32'd0);
  endtask

  // One full transaction: request, memory handshake after rdy_wait idle
  // cycles, read data after rv_wait further cycles.
  task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] rs1,
                               input logic [11:0] imm, input logic [31:0] sd,
                               input logic [4:0] rd, input logic [31:0] rdata,
                               input int rdy_wait, input int rv_wait);
    exp_t e;
    bit   done;
    e = model(st, f3, rs1, imm, sd, rdata);
    checkOutput("idle_ready", 32'(req.ready), 32'd1);
    req.valid      = 1'b1;
    req.is_store   = st;
    req.funct3     = f3;
    req.rs1        = rs1;
    req.imm        = imm;
    req.store_data = sd;
    req.rd         = rd;
    @(negedge clk);
    req.valid      = 1'b0;
    req.rs1        = $urandom;
    req.imm        = 12'($urandom);
    req.store_data = $urandom;
    req.rd         = 5'($urandom);
    if (e.fault) begin
      checkOutput("fault_exc_valid", 32'(req.exc_valid), 32'd1);
      checkOutput("fault_cause", 32'(req.exc_cause), 32'(e.cause));
      checkOutput("fault_addr", req.exc_addr, e.ea);
      checkOutput("fault_no_mem", 32'(mem.valid), 32'd0);
      checkOutput("fault_ready", 32'(req.ready), 32'd1);
      @(negedge clk);
      checkOutput("fault_pulse_end", 32'(req.exc_valid), 32'd0);
      checkOutput("fault_still_no_mem", 32'(mem.valid), 32'd0);
      return;
    end
    checkOutput("req_no_exc", 32'(req.exc_valid), 32'd0);
    checkOutput("req_stall", 32'(req.stall), 32'd1);
    checkOutput("req_not_ready", 32'(req.ready), 32'd0);
    checkOutput("mem_we", 32'(mem.we), 32'(st));
    checkOutput("mem_be", 32'(mem.be), 32'(e.be));
    if (st) checkOutput("mem_wdata", mem.wdata, e.wdata);
    done = 1'b0;
    for (int k = 1; k <= TIMEOUT && !done; k++) begin
      checkOutput("mem_valid_hold", 32'(mem.valid), 32'd1);
      checkOutput("mem_addr", mem.addr, e.addr);
      if (k == rdy_wait + 1) begin
        mem.ready = 1'b1;
        done      = 1'b1;
      end
      mem.rvalid = 1'($urandom_range(0, 1));
      mem.rdata  = $urandom;
      @(negedge clk);
      mem.ready  = 1'b0;
      mem.rvalid = 1'b0;
    end
    if (!done) begin
      checkTimeout(e.ea);
      return;
    end
    checkOutput("mem_valid_drop", 32'(mem.valid), 32'd0);
    checkOutput("hs_no_exc", 32'(req.exc_valid), 32'd0);
    checkOutput("hs_no_wb", 32'(req.wb_valid), 32'd0);
    if (st) begin
      checkOutput("store_ready", 32'(req.ready), 32'd1);
      checkOutput("store_stall", 32'(req.stall), 32'd0);
      return;
    end
    done = 1'b0;
    for (int k = 1; k <= TIMEOUT && !done; k++) begin
      checkOutput("wait_stall", 32'(req.stall), 32'd1);
      checkOutput("wait_no_wb", 32'(req.wb_valid), 32'd0);
      if (k == rv_wait + 1) begin
        mem.rvalid = 1'b1;
        mem.rdata  = rdata;
        done       = 1'b1;
      end else begin
        mem.rdata  = $urandom;
      end
      @(negedge clk);
      mem.rvalid = 1'b0;
      mem.rdata  = $urandom;
    end
    if (!done) begin
      checkTimeout(e.ea);
      return;
    end
    checkOutput("wb_valid", 32'(req.wb_valid), 32'(rd != 5'd0));
    checkOutput("wb_rd", 32'(req.wb_rd), 32'(rd));
    checkOutput("wb_data", req.wb_data, e.wb);
    checkOutput("resp_stall", 32'(req.stall), 32'd1);
    checkOutput("resp_no_exc", 32'(req.exc_valid), 32'd0);
    @(negedge clk);
    checkOutput("wb_pulse_end", 32'(req.wb_valid), 32'd0);
    checkOutput("resp_ready", 32'(req.ready), 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 32'(req.ready), 32'd1);
    checkOutput({tag, "_stall"}, 32'(req.stall), 32'd0);
    checkOutput({tag, "_mem_valid"}, 32'(mem.valid), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem.we), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem.addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem.wdata, 32'd0);
    checkOutput({tag, "_mem_be"}, 32'(mem.be), 32'd0);
    checkOutput({tag, "_wb_valid"}, 32'(req.wb_valid), 32'd0);
    checkOutput({tag, "_wb_data"}, req.wb_data, 32'd0);
    checkOutput({tag, "_wb_rd"}, 32'(req.wb_rd), 32'd0);
    checkOutput({tag, "_exc_valid"}, 32'(req.exc_valid), 32'd0);
    checkOutput({tag, "_exc_cause"}, 32'(req.exc_cause), 32'd0);
    checkOutput({tag, "_exc_addr"}, req.exc_addr, 32'd0);
  endtask

  initial begin
    int r, rw, vw;
    logic [31:0] rs1;
    logic [11:0] imm;

    rst_n          = 1'b0;
    req.valid      = 1'b0;
    req.is_store   = 1'b0;
    req.funct3     = 3'd0;
    req.rs1        = '0;
    req.imm        = '0;
    req.store_data = '0;
    req.rd         = '0;
    mem.ready      = 1'b0;
    mem.rvalid     = 1'b0;
    mem.rdata      = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(1'b0, 3'b010, 32'h1000, 12'h004, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0);
    applyStimulus(1'b0, 3'b000, 32'h2000, 12'h003, 32'h0, 5'd6, 32'h8000_0000, 0, 0);
    applyStimulus(1'b0, 3'b100, 32'h2000, 12'h003, 32'h0, 5'd7, 32'h8000_0000, 0, 0);
    applyStimulus(1'b1, 3'b001, 32'h3000, 12'hFFE, 32'h1234_ABCD, 5'd0, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b010, 32'h1000, 12'h002, 32'h0, 5'd8, 32'h0, 0, 0);
    applyStimulus(1'b1, 3'b011, 32'h1000, 12'h000, 32'h0, 5'd0, 32'h0, 0, 0);
    applyStimulus(1'b0, 3'b110, 32'h1000, 12'h000, 32'h0, 5'd9, 32'h0, 0, 0);
    applyStimulus(1'b1, 3'b010, 32'h4000, 12'h000, 32'h5555_AAAA, 5'd0, 32'h0, TIMEOUT, 0);
    applyStimulus(1'b1, 3'b010, 32'h4000, 12'h000, 32'h5555_AAAA, 5'd0, 32'h0, TIMEOUT-1, 0);
    applyStimulus(1'b0, 3'b001, 32'h5002, 12'h000, 32'h0, 5'd10, 32'h8001_7FFF, 0, TIMEOUT);
    applyStimulus(1'b0, 3'b101, 32'h5002, 12'h000, 32'h0, 5'd11, 32'h8001_7FFF, 2, TIMEOUT-1);
    applyStimulus(1'b0, 3'b010, 32'h6000, 12'h7FC, 32'h0, 5'd0, 32'h1357_9BDF, 0, 0);
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFF0, 12'h010, 32'h0, 5'd12, 32'hCAFE_F00D, 1, 1);

    $display("[TB] reset during WAIT_RD");
    req.valid  = 1'b1;
    req.is_store = 1'b0;
    req.funct3 = 3'b010;
    req.rs1    = 32'h7000;
    req.imm    = 12'h008;
    req.rd     = 5'd13;
    @(negedge clk);
    req.valid  = 1'b0;
    mem.ready  = 1'b1;
    @(negedge clk);
    mem.ready  = 1'b0;
    checkOutput("pre_reset_stall", 32'(req.stall), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkResetState("async_reset");
    @(negedge clk);
    rst_n      = 1'b1;
    mem.rvalid = 1'b1;
    mem.rdata  = 32'h1111_2222;
    @(negedge clk);
    mem.rvalid = 1'b0;
    checkOutput("post_reset_no_wb", 32'(req.wb_valid), 32'd0);
    checkOutput("post_reset_ready", 32'(req.ready), 32'd1);
    @(negedge clk);
    checkOutput("post_reset_no_wb2", 32'(req.wb_valid), 32'd0);
    checkOutput("post_reset_no_exc", 32'(req.exc_valid), 32'd0);

    $display("[TB] random transactions");
    for (int n = 0; n < 300; n++) begin
      rs1 = $urandom;
      imm = 12'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rs1[1:0] = 2'b00;
        imm[1:0] = 2'b00;
      end
      r  = $urandom_range(0, 9);
      rw = (r < 6) ? r % 3 : ((r < 8) ? TIMEOUT - 1 : TIMEOUT + r - 8);
      r  = $urandom_range(0, 9);
      vw = (r < 6) ? r % 3 : ((r < 8) ? TIMEOUT - 1 : TIMEOUT + r - 8);
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rs1, imm,
                    $urandom, 5'($urandom), $urandom, rw, vw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
